core_rf_wb_arb: RTL and testbench
=================================

# core_rf_wb_arb

Writeback arbiter and register scoreboard for the 16-entry GPR file. Two producers, the ALU (port 0) and the load/store unit (port 1), compete for the single GPR write port through valid/ready handshakes. The block grants one per cycle round-robin and drives a registered write (wb/wb_addr/wb_data) into the GPR. A 16-bit pending scoreboard is set by issue, cleared by writeback and queried combinationally by decode for operand hazards.

## Interface
- No parameters; data width 32, address width 4, fixed.
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_addr  in  4  ALU destination register
- alu_data  in  32  ALU result
- lsu_valid  in  1  LSU writeback request
- lsu_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  4  LSU destination register
- lsu_data  in  32  LSU load data
- wb  out  1  GPR write enable, registered
- wb_addr  out  4  GPR write address, registered
- wb_data  out  32  GPR write data, registered
- sb_set  in  1  issue marks destination pending
- sb_set_addr  in  4  destination being issued
- sb_conflict  out  1  pending[sb_set_addr], combinational
- rega_addr  in  4  decode operand A address
- regb_addr  in  4  decode operand B address
- rega_busy  out  1  pending[rega_addr], combinational
- regb_busy  out  1  pending[regb_addr], combinational

## Operation
- Arbitration (combinational grant, one per cycle):
  - only alu_valid → grant ALU; only lsu_valid → grant LSU; neither → no grant.
  - both valid → grant the port not granted last (last_grant register).
  - last_grant updates only on an accepted grant; reset value = LSU, so ALU wins the first contention.
- alu_ready/lsu_ready = grant for that port, gated low while rst is high. Handshake = valid & ready. Ready never asserts without valid.
- An accepted request is registered: the next cycle wb=1 and wb_addr/wb_data equal the winner's addr/data. With no grant, the next cycle wb=0 and wb_addr/wb_data hold their previous values.
- Requesters hold valid/addr/data stable until ready. Valid may drop only after acceptance.
- Scoreboard pending[15:0]:
  - set: sb_set=1 sets pending[sb_set_addr] at the clock edge.
  - clear: registered wb=1 clears pending[wb_addr] at the same edge the GPR captures the write.
  - set and clear to the same address in one cycle → set wins, bit stays 1.
  - set and clear to different addresses → both take effect.
  - clear of an address that is not pending → no effect.
- Issue must stall while sb_conflict=1. The block does not track multiple outstanding writes to one register.
- Busy outputs reflect the registered pending state only. There is no forwarding of the same-cycle wb.

## Timing
- Reset (rst=1 at an edge): wb=0, wb_addr=0, wb_data=0, pending=0, last_grant=LSU. While rst=1: alu_ready=lsu_ready=0.
- Reset mid-operation: a request accepted in the cycle before rst is dropped if rst is high at the edge that would register it. In-flight pending bits are cleared, so the issue stage must be flushed together with this block.
- Latency: handshake at cycle N → wb=1 during N+1 → GPR written and pending cleared at the end of N+1 → rega_busy=0 in N+2.
- Throughput: one writeback per cycle. Under continuous dual requests the ports alternate strictly: ALU, LSU, ALU, …
- sb_set in cycle N → busy visible in N+1.

## Test plan
- Reset: assert rst 2 cycles with alu_valid=lsu_valid=1 → readies 0, wb=0, pending=0. After rst drops, the first grant goes to ALU.
- Single ALU: alu_valid, addr=3, data=0xDEADBEEF at cycle N → alu_ready=1 in N; wb=1, wb_addr=3, wb_data=0xDEADBEEF in N+1; wb=0 in N+2.
- Contention: both valid continuously for 6 cycles (ALU addr 1, LSU addr 2) → grant sequence ALU, LSU, ALU, LSU, ALU, LSU; wb_addr sequence 1, 2, 1, 2, 1, 2 lagging by one cycle.
- Scoreboard: sb_set addr 5 → rega_addr=5 gives rega_busy=1 next cycle. LSU writeback to 5 accepted at N → rega_busy=0 at N+2. sb_conflict=1 for addr 5 throughout that window.
- Set/clear collision: wb to addr 7 and sb_set addr 7 in the same cycle → pending[7] remains 1. The same collision with different addresses (wb 7, set 8) → pending[7]=0, pending[8]=1.
- Mid-op reset: grant an ALU request at cycle N with rst=1 at the N/N+1 edge → wb=0 in N+1 and all busy outputs 0.

Source files
------------

// File: rtl/core_rf_wb_arb.sv
// Writeback arbiter for the single GPR write port (ALU vs LSU, round-robin on contention)
// plus the 16-entry pending-register scoreboard that decode queries for operand hazards.
module core_rf_wb_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [3:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [3:0]  lsu_addr,
  input  logic [31:0] lsu_data,
  output logic        wb,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_data,
  input  logic        sb_set,
  input  logic [3:0]  sb_set_addr,
  output logic        sb_conflict,
  input  logic [3:0]  rega_addr,
  input  logic [3:0]  regb_addr,
  output logic        rega_busy,
  output logic        regb_busy
);

  typedef enum logic {
    PORT_ALU = 1'b0,
    PORT_LSU = 1'b1
  } port_e;

  port_e       lastGrant_q, lastGrant_d;
  logic        wb_q, wb_d;
  logic [3:0]  wbAddr_q, wbAddr_d;
  logic [31:0] wbData_q, wbData_d;
  logic [15:0] pending_q, pending_d;
  logic        grantAlu, grantLsu;
  logic        aluAccept, lsuAccept;

  // On contention the port that did not win last time gets the write port.
  always_comb begin
    grantAlu = alu_valid & (~lsu_valid | (lastGrant_q == PORT_LSU));
    grantLsu = lsu_valid & (~alu_valid | (lastGrant_q == PORT_ALU));
  end

  assign alu_ready = grantAlu & ~rst;
  assign lsu_ready = grantLsu & ~rst;
  assign aluAccept = alu_valid & alu_ready;
  assign lsuAccept = lsu_valid & lsu_ready;

  // Next-state for the write register, round-robin pointer and scoreboard.
  // Clear is applied before set so a same-address collision leaves the bit set.
  always_comb begin
    lastGrant_d = lastGrant_q;
    wb_d        = aluAccept | lsuAccept;
    wbAddr_d    = wbAddr_q;
    wbData_d    = wbData_q;
    if (aluAccept) begin
      lastGrant_d = PORT_ALU;
      wbAddr_d    = alu_addr;
      wbData_d    = alu_data;
    end else if (lsuAccept) begin
      lastGrant_d = PORT_LSU;
      wbAddr_d    = lsu_addr;
      wbData_d    = lsu_data;
    end

    pending_d = pending_q;
    if (wb_q) begin
      pending_d[wbAddr_q] = 1'b0;
    end
    if (sb_set) begin
      pending_d[sb_set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrant_q <= PORT_LSU;
      wb_q        <= 1'b0;
      wbAddr_q    <= 4'd0;
      wbData_q    <= 32'd0;
      pending_q   <= 16'd0;
    end else begin
      lastGrant_q <= lastGrant_d;
      wb_q        <= wb_d;
      wbAddr_q    <= wbAddr_d;
      wbData_q    <= wbData_d;
      pending_q   <= pending_d;
    end
  end

  assign wb          = wb_q;
  assign wb_addr     = wbAddr_q;
  assign wb_data     = wbData_q;
  assign sb_conflict = pending_q[sb_set_addr];
  assign rega_busy   = pending_q[rega_addr];
  assign regb_busy   = pending_q[regb_addr];

endmodule

// File: tb/tb_core_rf_wb_arb.sv
// Self-checking bench for core_rf_wb_arb: directed scenarios plus a randomized run
// compared against a small behavioural model of the arbiter and scoreboard.
module tb_core_rf_wb_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [3:0]  alu_addr, lsu_addr;
  logic [31:0] alu_data, lsu_data;
  logic        wb;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        sb_set, sb_conflict;
  logic [3:0]  sb_set_addr, rega_addr, regb_addr;
  logic        rega_busy, regb_busy;

  int total = 0;
  int bad   = 0;

  // Behavioural model: who won last, which registers are pending, what is on the write port.
  bit          mLastLsu;
  bit          mPend [16];
  bit          mWb;
  logic [3:0]  mWbAddr;
  logic [31:0] mWbData;

  core_rf_wb_arb dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .wb(wb), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr), .sb_conflict(sb_conflict),
    .rega_addr(rega_addr), .regb_addr(regb_addr), .rega_busy(rega_busy), .regb_busy(regb_busy)
  );

  always #5 clk = ~clk;

  function automatic bit expAlu();
    return !rst && alu_valid && (!lsu_valid || mLastLsu);
  endfunction

  function automatic bit expLsu();
    return !rst && lsu_valid && (!alu_valid || !mLastLsu);
  endfunction

  // Advance the model by one clock edge using the inputs the bench is driving.
  task automatic modelEdge();
    bit a, l;
    a = expAlu();
    l = expLsu();
    if (rst) begin
      mLastLsu = 1'b1;
      foreach (mPend[i]) mPend[i] = 1'b0;
      mWb = 1'b0; mWbAddr = '0; mWbData = '0;
    end else begin
      if (mWb) mPend[mWbAddr] = 1'b0;
      if (sb_set) mPend[sb_set_addr] = 1'b1;
      mWb = a || l;
      if (a) begin
        mWbAddr = alu_addr; mWbData = alu_data; mLastLsu = 1'b0;
      end else if (l) begin
        mWbAddr = lsu_addr; mWbData = lsu_data; mLastLsu = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0; sb_set = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; alu_valid = 1'b1; lsu_valid = 1'b1; alu_addr = 4'd1; lsu_addr = 4'd2;
    tick(); tick();
    total++; if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_ready got=%b%b exp=00", alu_ready, lsu_ready); end
    total++; if (wb !== 1'b0) begin bad++; $display("[TB] FAIL reset_wb got=%b exp=0", wb); end
    for (int i = 0; i < 16; i++) begin
      rega_addr = 4'(i); regb_addr = 4'(15 - i); #1;
      total++; if (rega_busy !== 1'b0 || regb_busy !== 1'b0) begin
        bad++; $display("[TB] FAIL reset_busy reg=%0d got=%b%b exp=00", i, rega_busy, regb_busy); end
    end
    rst = 1'b0; #1;
    total++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_first_grant got=%b%b exp=10", alu_ready, lsu_ready); end
    tick();
    alu_valid = 1'b0; lsu_valid = 1'b0;
  endtask

  task automatic test_single_alu();
    doReset();
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'hDEADBEEF; #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("[TB] FAIL single_ready got=%b exp=1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    total++; if (wb !== 1'b1 || wb_addr !== 4'd3 || wb_data !== 32'hDEADBEEF) begin
      bad++; $display("[TB] FAIL single_wb got=%b/%0d/%h exp=1/3/deadbeef", wb, wb_addr, wb_data); end
    tick();
    total++; if (wb !== 1'b0 || wb_data !== 32'hDEADBEEF) begin
      bad++; $display("[TB] FAIL single_idle got=%b/%h exp=0/deadbeef", wb, wb_data); end
  endtask

  task automatic test_contention();
    doReset();
    alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'h1111_0001;
    lsu_valid = 1'b1; lsu_addr = 4'd2; lsu_data = 32'h2222_0002;
    for (int c = 0; c < 6; c++) begin
      #1;
      total++; if (alu_ready !== (c % 2 == 0) || lsu_ready !== (c % 2 == 1)) begin
        bad++; $display("[TB] FAIL contention_grant cyc=%0d got=%b%b exp_alu=%0d", c, alu_ready, lsu_ready, c % 2 == 0); end
      tick();
      total++; if (wb !== 1'b1 || wb_addr !== ((c % 2 == 0) ? 4'd1 : 4'd2)) begin
        bad++; $display("[TB] FAIL contention_wb cyc=%0d got=%b/%0d", c, wb, wb_addr); end
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
  endtask

  task automatic test_scoreboard();
    doReset();
    sb_set = 1'b1; sb_set_addr = 4'd5;
    tick();
    sb_set = 1'b0; rega_addr = 4'd5; regb_addr = 4'd6;
    lsu_valid = 1'b1; lsu_addr = 4'd5; lsu_data = 32'h0BAD_F00D; #1;
    total++; if (rega_busy !== 1'b1 || regb_busy !== 1'b0 || sb_conflict !== 1'b1) begin
      bad++; $display("[TB] FAIL sb_set got=%b%b%b exp=101", rega_busy, regb_busy, sb_conflict); end
    total++; if (lsu_ready !== 1'b1) begin bad++; $display("[TB] FAIL sb_lsu_ready got=%b exp=1", lsu_ready); end
    tick();
    lsu_valid = 1'b0; #1;
    total++; if (wb !== 1'b1 || rega_busy !== 1'b1 || sb_conflict !== 1'b1) begin
      bad++; $display("[TB] FAIL sb_wb_cycle got=%b%b%b exp=111", wb, rega_busy, sb_conflict); end
    tick();
    total++; if (rega_busy !== 1'b0 || sb_conflict !== 1'b0) begin
      bad++; $display("[TB] FAIL sb_cleared got=%b%b exp=00", rega_busy, sb_conflict); end
  endtask

  task automatic test_collision();
    doReset();
    alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 32'h7;
    tick();
    alu_valid = 1'b0; sb_set = 1'b1; sb_set_addr = 4'd7;
    tick();
    sb_set = 1'b0; rega_addr = 4'd7; #1;
    total++; if (rega_busy !== 1'b1) begin bad++; $display("[TB] FAIL collide_same got=%b exp=1", rega_busy); end

    doReset();
    sb_set = 1'b1; sb_set_addr = 4'd7;
    tick();
    sb_set = 1'b0; alu_valid = 1'b1; alu_addr = 4'd7;
    tick();
    alu_valid = 1'b0; sb_set = 1'b1; sb_set_addr = 4'd8;
    tick();
    sb_set = 1'b0; rega_addr = 4'd7; regb_addr = 4'd8; #1;
    total++; if (rega_busy !== 1'b0 || regb_busy !== 1'b1) begin
      bad++; $display("[TB] FAIL collide_diff got=%b%b exp=01", rega_busy, regb_busy); end
  endtask

  task automatic test_midop_reset();
    doReset();
    sb_set = 1'b1; sb_set_addr = 4'd4;
    tick();
    sb_set = 1'b0; alu_valid = 1'b1; alu_addr = 4'd9; alu_data = 32'h9999; #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_ready got=%b exp=1", alu_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0; alu_valid = 1'b0; rega_addr = 4'd4; regb_addr = 4'd9; sb_set_addr = 4'd4; #1;
    total++; if (wb !== 1'b0 || rega_busy !== 1'b0 || regb_busy !== 1'b0 || sb_conflict !== 1'b0) begin
      bad++; $display("[TB] FAIL midrst_state got=%b%b%b%b exp=0000", wb, rega_busy, regb_busy, sb_conflict); end
  endtask

  task automatic test_random();
    bit aAcc = 1'b0, lAcc = 1'b0;
    doReset();
    for (int n = 0; n < 500; n++) begin
      if (!alu_valid || aAcc) begin
        alu_valid = $urandom_range(0, 1); alu_addr = 4'($urandom); alu_data = $urandom;
      end
      if (!lsu_valid || lAcc) begin
        lsu_valid = $urandom_range(0, 1); lsu_addr = 4'($urandom); lsu_data = $urandom;
      end
      sb_set = ($urandom_range(0, 2) == 0); sb_set_addr = 4'($urandom);
      rega_addr = 4'($urandom); regb_addr = 4'($urandom);
      rst = ($urandom_range(0, 63) == 0);
      #1;
      total++; if (alu_ready !== expAlu() || lsu_ready !== expLsu()) begin
        bad++; $display("[TB] FAIL rand_ready n=%0d got=%b%b exp=%b%b", n, alu_ready, lsu_ready, expAlu(), expLsu()); end
      total++; if (wb !== mWb || wb_addr !== mWbAddr || wb_data !== mWbData) begin
        bad++; $display("[TB] FAIL rand_wb n=%0d got=%b/%0d/%h exp=%b/%0d/%h", n, wb, wb_addr, wb_data, mWb, mWbAddr, mWbData); end
      total++; if (rega_busy !== mPend[rega_addr] || regb_busy !== mPend[regb_addr] || sb_conflict !== mPend[sb_set_addr]) begin
        bad++; $display("[TB] FAIL rand_busy n=%0d got=%b%b%b exp=%b%b%b", n, rega_busy, regb_busy, sb_conflict,
                        mPend[rega_addr], mPend[regb_addr], mPend[sb_set_addr]); end
      aAcc = expAlu();
      lAcc = expLsu();
      tick();
    end
    rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0; sb_set = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0; alu_addr = '0; lsu_addr = '0;
    alu_data = '0; lsu_data = '0; sb_set = 1'b0; sb_set_addr = '0; rega_addr = '0; regb_addr = '0;
    mLastLsu = 1'b1; mWb = 1'b0; mWbAddr = '0; mWbData = '0;
    foreach (mPend[i]) mPend[i] = 1'b0;
    test_reset();
    test_single_alu();
    test_contention();
    test_scoreboard();
    test_collision();
    test_midop_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
